// File: rtl/subsurf_pkg.sv
// Shared constants and types for the subdivision-surface front end.
package subsurf_pkg;

   localparam int unsigned ADDR_WIDTH_DEFAULT = 11;

   // Reserved word value that ends a mesh stream; never stored.
   localparam logic [31:0] MESH_TERMINATOR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StCheck,
      StDone
   } loader_state_t;

endpackage

// File: rtl/pulse_sync.sv
// Brings an asynchronous level into the clk domain and emits a one-cycle pulse on its rising
// edge. Latency from input rise to pulse is SYNC_STAGES+1 cycles.
module pulse_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchronizer chain, delayed copy and registered rising-edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
         pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

endmodule

// File: rtl/spi_mesh_loader.sv
// Loads SPI-received words into the mesh RAM from address 0 until the terminator word, then
// pulses mesh_ready with the stored word count.
// Optional feature: define SPI_LOADER_CSUM_EN to add a trailing checksum word and csum_err.
module spi_mesh_loader
   import subsurf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic                  spi_done,
   input  logic [31:0]           spi_rdata,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic                  busy,
   output logic                  mesh_ready,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  overflow
`ifdef SPI_LOADER_CSUM_EN
   ,
   output logic                  csum_err
`endif
);

   localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   loader_state_t state_q, state_d;

   logic        word_ev;
   logic        ev_q;
   logic [31:0] hold_q;
   logic        active;
   logic        do_write;
   logic        arm;

`ifdef SPI_LOADER_CSUM_EN
   logic [31:0] sum_q;
`endif

   pulse_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_done_sync (
      .clk   (clk),
      .reset (reset),
      .din   (spi_done),
      .pulse (word_ev)
   );

   // Decode event qualification and the write decision for the current cycle.
   always_comb begin
      active   = (state_q == StLoad) || (state_q == StCheck);
      arm      = (state_q == StIdle) && load_en;
      do_write = word_ev && (state_q == StLoad) && (spi_rdata != MESH_TERMINATOR) &&
                 (word_count < CAPACITY);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stream decisions use the word captured on the previous event.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (load_en) state_d = StLoad;
         end
         StLoad: begin
            if (ev_q && (hold_q == MESH_TERMINATOR)) begin
`ifdef SPI_LOADER_CSUM_EN
               state_d = StCheck;
`else
               state_d = StDone;
`endif
            end
         end
         StCheck: begin
            if (ev_q) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Capture, RAM port registers, count, overflow and checksum tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         ev_q       <= 1'b0;
         hold_q     <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 4'b0000;
         ram_addr   <= '0;
         ram_din    <= '0;
         word_count <= '0;
         overflow   <= 1'b0;
`ifdef SPI_LOADER_CSUM_EN
         sum_q      <= '0;
         csum_err   <= 1'b0;
`endif
      end else begin
         ev_q   <= word_ev && active;
         ram_en <= 1'b0;
         ram_we <= 4'b0000;
         if (word_ev) hold_q <= spi_rdata;
         if (do_write) begin
            ram_en   <= 1'b1;
            ram_we   <= 4'b1111;
            ram_addr <= word_count[ADDR_WIDTH-1:0];
            ram_din  <= spi_rdata;
         end
         if (arm) begin
            word_count <= '0;
            overflow   <= 1'b0;
`ifdef SPI_LOADER_CSUM_EN
            sum_q      <= '0;
            csum_err   <= 1'b0;
`endif
         end
         // Count advances in the cycle the write is presented to the RAM.
         if (ram_en) begin
            word_count <= word_count + COUNT_ONE;
`ifdef SPI_LOADER_CSUM_EN
            sum_q      <= sum_q + ram_din;
`endif
         end
         if (ev_q && (state_q == StLoad) && (hold_q != MESH_TERMINATOR) &&
             (word_count == CAPACITY)) begin
            overflow <= 1'b1;
         end
`ifdef SPI_LOADER_CSUM_EN
         if (ev_q && (state_q == StCheck)) begin
            csum_err <= (hold_q != sum_q);
         end
`endif
      end
   end

   // Status decodes.
   always_comb begin
      busy       = (state_q == StLoad) || (state_q == StCheck);
      mesh_ready = (state_q == StDone);
   end

endmodule

// File: tb/tb_spi_mesh_loader.sv
// Directed bench for spi_mesh_loader: a default-size instance and an ADDR_WIDTH=2 instance share
// the same stimulus; simple RAM monitors record what each one writes.
module tb_spi_mesh_loader;

   logic        clk;
   logic        reset;
   logic        load_en;
   logic        spi_done;
   logic [31:0] spi_rdata;
   logic        clr_mon;

   logic        ram_en, busy, mesh_ready, overflow;
   logic [3:0]  ram_we;
   logic [10:0] ram_addr;
   logic [31:0] ram_din;
   logic [11:0] word_count;

   logic        s_ram_en, s_busy, s_mesh_ready, s_overflow;
   logic [3:0]  s_ram_we;
   logic [1:0]  s_ram_addr;
   logic [31:0] s_ram_din;
   logic [2:0]  s_word_count;

`ifdef SPI_LOADER_CSUM_EN
   logic        csum_err, s_csum_err;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mem   [0:7];
   logic [31:0] mem_s [0:3];
   logic [7:0]  wr_mask;
   int          wr_cnt, s_wr_cnt, rdy_cnt, bad_we;

   spi_mesh_loader #(
      .ADDR_WIDTH  (11),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_en),
      .spi_done   (spi_done),
      .spi_rdata  (spi_rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .busy       (busy),
      .mesh_ready (mesh_ready),
      .word_count (word_count),
      .overflow   (overflow)
`ifdef SPI_LOADER_CSUM_EN
      ,
      .csum_err   (csum_err)
`endif
   );

   spi_mesh_loader #(
      .ADDR_WIDTH  (2),
      .SYNC_STAGES (2)
   ) dut_small (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_en),
      .spi_done   (spi_done),
      .spi_rdata  (spi_rdata),
      .ram_en     (s_ram_en),
      .ram_we     (s_ram_we),
      .ram_addr   (s_ram_addr),
      .ram_din    (s_ram_din),
      .busy       (s_busy),
      .mesh_ready (s_mesh_ready),
      .word_count (s_word_count),
      .overflow   (s_overflow)
`ifdef SPI_LOADER_CSUM_EN
      ,
      .csum_err   (s_csum_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models and event counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (clr_mon) begin
         wr_cnt   <= 0;
         s_wr_cnt <= 0;
         rdy_cnt  <= 0;
         wr_mask  <= '0;
         for (int i = 0; i < 8; i++) mem[i] <= '0;
         for (int i = 0; i < 4; i++) mem_s[i] <= '0;
      end else begin
         if (ram_en) begin
            wr_cnt <= wr_cnt + 1;
            if (ram_addr < 11'd8) begin
               mem[ram_addr[2:0]]     <= ram_din;
               wr_mask[ram_addr[2:0]] <= 1'b1;
            end
         end
         if (s_ram_en) begin
            s_wr_cnt          <= s_wr_cnt + 1;
            mem_s[s_ram_addr] <= s_ram_din;
         end
         if (mesh_ready) rdy_cnt <= rdy_cnt + 1;
      end
      if ((ram_en && ram_we != 4'b1111) || (!ram_en && ram_we != 4'b0000)) bad_we <= bad_we + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk);
      clr_mon = 1'b1;
      @(posedge clk);
      clr_mon = 1'b0;
   endtask

   task automatic arm();
      @(negedge clk);
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // One SPI word: flag high for 8 cycles then low for 40, well above the event spacing floor.
   task automatic send_word(input logic [31:0] w);
      @(negedge clk);
      spi_rdata = w;
      spi_done  = 1'b1;
      repeat (8) @(negedge clk);
      spi_done  = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   initial begin
      bad_we    = 0;
      reset     = 1'b1;
      load_en   = 1'b0;
      spi_done  = 1'b0;
      spi_rdata = '0;
      clr_mon   = 1'b0;
      repeat (3) @(negedge clk);
      clear_mon();

      // Reset state.
      @(negedge clk);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_busy", busy, 0);
      check("rst_mesh_ready", mesh_ready, 0);
      check("rst_word_count", word_count, 0);
      check("rst_overflow", overflow, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Three words then terminator.
      arm();
      check("t1_busy_armed", busy, 1);
      send_word(32'h11);
      send_word(32'h22);
      send_word(32'h33);
      check("t1_busy_before_term", busy, 1);
      send_word(32'hFFFF_FFFF);
      check("t1_ram0", mem[0], 32'h11);
      check("t1_ram1", mem[1], 32'h22);
      check("t1_ram2", mem[2], 32'h33);
      check("t1_ram3_untouched", wr_mask[3], 0);
      check("t1_writes", wr_cnt, 3);
      check("t1_word_count", word_count, 3);
      check("t1_ready_pulses", rdy_cnt, 1);
      check("t1_busy_after", busy, 0);
      check("t1_overflow", overflow, 0);

      // Word events in IDLE are ignored.
      clear_mon();
      send_word(32'h55);
      check("idle_writes", wr_cnt, 0);
      check("idle_word_count", word_count, 3);
      check("idle_ready", rdy_cnt, 0);

      // Empty mesh.
      clear_mon();
      arm();
      check("empty_count_cleared", word_count, 0);
      send_word(32'hFFFF_FFFF);
      check("empty_word_count", word_count, 0);
      check("empty_ready_pulses", rdy_cnt, 1);
      check("empty_writes", wr_cnt, 0);

      // Overflow on the 4-word instance; the large instance takes all six.
      clear_mon();
      arm();
      for (int i = 0; i < 6; i++) send_word(32'hA0 + i);
      send_word(32'hFFFF_FFFF);
      check("ovf_s_ram0", mem_s[0], 32'hA0);
      check("ovf_s_ram1", mem_s[1], 32'hA1);
      check("ovf_s_ram2", mem_s[2], 32'hA2);
      check("ovf_s_ram3", mem_s[3], 32'hA3);
      check("ovf_s_writes", s_wr_cnt, 4);
      check("ovf_s_word_count", s_word_count, 4);
      check("ovf_s_overflow", s_overflow, 1);
      check("ovf_s_busy", s_busy, 0);
      check("ovf_big_word_count", word_count, 6);
      check("ovf_big_overflow", overflow, 0);
      check("ovf_big_ram5", mem[5], 32'hA5);
      repeat (5) @(negedge clk);
      check("ovf_s_sticky", s_overflow, 1);

      // Reset during a load, then a fresh load from address 0.
      clear_mon();
      arm();
      check("mid_s_overflow_cleared", s_overflow, 0);
      send_word(32'hB0);
      send_word(32'hB1);
      check("mid_count_before_rst", word_count, 2);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_word_count", word_count, 0);
      check("mid_rst_ram_addr", ram_addr, 0);
      check("mid_rst_ram_din", ram_din, 0);
      check("mid_rst_ram_en", ram_en, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      clear_mon();
      arm();
      send_word(32'hC0);
      send_word(32'hFFFF_FFFF);
      check("mid_reload_ram0", mem[0], 32'hC0);
      check("mid_reload_addr0_only", wr_mask, 8'h01);
      check("mid_reload_count", word_count, 1);
      check("mid_reload_ready", rdy_cnt, 1);

`ifdef SPI_LOADER_CSUM_EN
      // Checksum trailer: matching then mismatching sum.
      clear_mon();
      arm();
      send_word(32'd1);
      send_word(32'd2);
      send_word(32'd3);
      send_word(32'hFFFF_FFFF);
      check("csum_busy_in_check", busy, 1);
      send_word(32'd6);
      check("csum_ok_err", csum_err, 0);
      check("csum_ok_count", word_count, 3);
      check("csum_ok_writes", wr_cnt, 3);
      check("csum_ok_ready", rdy_cnt, 1);
      clear_mon();
      arm();
      send_word(32'd1);
      send_word(32'd2);
      send_word(32'd3);
      send_word(32'hFFFF_FFFF);
      send_word(32'd7);
      check("csum_bad_err", csum_err, 1);
      check("csum_bad_count", word_count, 3);
      check("csum_bad_ready", rdy_cnt, 1);
`endif

      check("we_encoding", bad_we, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
